// File: rtl/xor_chain_sampler.sv
// xor_chain_sampler: windowed ones-counter for the eight XOR chain taps.
// Counts how often each tap is high over WINDOW accepted samples and offers
// the eight counts to a consumer through a valid/ready handshake.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; last window's counts remain readable
//   ACCUM | counting taps on every cycle with sample_en high
//   DONE  | window complete; counts frozen, result_valid high until ready
module xor_chain_sampler #(
  parameter int WINDOW = 256,
  localparam int CW = $clog2(WINDOW + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      tap_in,
  input  logic            sample_en,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [8*CW-1:0] counts,
  output logic [CW-1:0]   samples
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] WIN_LOAD = CW'(WINDOW);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t        state;
  // Samples still needed to close the window; the window ends when the
  // last one is accepted (terminal count of one).
  logic [CW-1:0] remaining;

  // Sequencer, counters and registered status outputs; abort overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      counts       <= '0;
      samples      <= '0;
      remaining    <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else if (abort) begin
      state        <= IDLE;
      counts       <= '0;
      samples      <= '0;
      remaining    <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ACCUM;
            counts    <= '0;
            samples   <= '0;
            remaining <= WIN_LOAD;
            busy      <= 1'b1;
          end
        end
        ACCUM: begin
          if (sample_en) begin
            for (int i = 0; i < 8; i++) begin
              counts[i*CW +: CW] <= counts[i*CW +: CW] + CW'(tap_in[i]);
            end
            samples   <= samples + ONE;
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              state        <= DONE;
              result_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
